otter_iobus_timer: RTL and testbench

- Memory-mapped programmable down-counter timer that sits on the OTTER IOBUS as a responder.
- It decodes CPU store cycles (IOBUS_ADDR/IOBUS_OUT/IOBUS_WR) into control registers and returns register readback on IOBUS_IN.
- It raises the CPU INTR input on expiry, giving the Pong game loop a fixed frame tick.
- Readback is zero when the block is unselected, so IOBUS_IN from several peripherals can be OR-combined at top level.

---
 rtl/otter_iobus_timer.sv | 152 +++++++++++++++
 tb/tb_otter_iobus_timer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_iobus_timer.sv
// Memory-mapped programmable down-counter timer on the OTTER IOBUS.
// Raises INTR for a fixed number of cycles on each expiry.
module otter_iobus_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
   parameter int unsigned INTR_HOLD = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IOBUS_IN,
   output logic        INTR
);

   localparam int unsigned DW = 32;
   localparam int unsigned PW = 16;
   localparam int unsigned HW = 4;

   localparam logic [2:0] IDX_CTRL     = 3'd0;
   localparam logic [2:0] IDX_PRESCALE = 3'd1;
   localparam logic [2:0] IDX_RELOAD   = 3'd2;
   localparam logic [2:0] IDX_COUNT    = 3'd3;
   localparam logic [2:0] IDX_STATUS   = 3'd4;

   logic          r_en;
   logic          r_auto;
   logic          r_irq_en;
   logic [PW-1:0] r_prescale;
   logic [DW-1:0] r_reload;
   logic [DW-1:0] r_count;
   logic          r_expired;
   logic [PW-1:0] r_pcnt;
   logic [HW-1:0] r_hold;

   logic          w_sel;
   logic [2:0]    w_idx;
   logic          w_wr;
   logic          w_wr_ctrl;
   logic          w_wr_pre;
   logic          w_wr_rel;
   logic          w_wr_cnt;
   logic          w_wr_sta;
   logic          w_tick;
   logic          w_zero;
   logic          w_expire;
   logic          w_en_next;
   logic          w_en_rise;
   logic [DW-1:0] w_rdata;
   logic          w_unused_addr;

   // Address decode; byte-lane bits are don't-care since writes are full-word
   assign w_sel         = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
   assign w_idx         = IOBUS_ADDR[4:2];
   assign w_unused_addr = ^IOBUS_ADDR[1:0];
   assign w_wr          = IOBUS_WR & w_sel;
   assign w_wr_ctrl     = w_wr && (w_idx == IDX_CTRL);
   assign w_wr_pre      = w_wr && (w_idx == IDX_PRESCALE);
   assign w_wr_rel      = w_wr && (w_idx == IDX_RELOAD);
   assign w_wr_cnt      = w_wr && (w_idx == IDX_COUNT);
   assign w_wr_sta      = w_wr && (w_idx == IDX_STATUS);

   assign w_tick   = r_en && (r_pcnt == r_prescale);
   assign w_zero   = (r_count == '0);
   assign w_expire = w_tick && w_zero;

   // A CPU write to CTRL overrides the one-shot auto-disable
   always_comb begin
      w_en_next = r_en;
      if (w_wr_ctrl) begin
         w_en_next = IOBUS_OUT[0];
      end else if (w_expire && !r_auto) begin
         w_en_next = 1'b0;
      end
   end

   assign w_en_rise = w_wr_ctrl && IOBUS_OUT[0] && !r_en;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_en       <= 1'b0;
         r_auto     <= 1'b0;
         r_irq_en   <= 1'b0;
         r_prescale <= '0;
         r_reload   <= '0;
         r_count    <= '0;
         r_expired  <= 1'b0;
         r_pcnt     <= '0;
         r_hold     <= '0;
      end else begin
         r_en <= w_en_next;
         if (w_wr_ctrl) begin
            r_auto   <= IOBUS_OUT[1];
            r_irq_en <= IOBUS_OUT[2];
         end
         if (w_wr_pre) begin
            r_prescale <= IOBUS_OUT[PW-1:0];
         end
         if (w_wr_rel) begin
            r_reload <= IOBUS_OUT;
         end

         if (w_wr_cnt) begin
            r_count <= IOBUS_OUT;
         end else if (w_tick) begin
            if (!w_zero) begin
               r_count <= r_count - DW'(1);
            end else if (r_auto) begin
               r_count <= r_reload;
            end
         end

         // Expiry set beats a same-cycle software clear
         if (w_expire) begin
            r_expired <= 1'b1;
         end else if (w_wr_sta && IOBUS_OUT[0]) begin
            r_expired <= 1'b0;
         end

         if (!w_en_next || w_en_rise || w_tick) begin
            r_pcnt <= '0;
         end else begin
            r_pcnt <= r_pcnt + PW'(1);
         end

         if (w_expire && r_irq_en) begin
            r_hold <= HW'(INTR_HOLD);
         end else if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
         end
      end
   end

   // Zero when unselected so readback can be OR-combined at top level
   always_comb begin
      w_rdata = '0;
      if (w_sel) begin
         case (w_idx)
            IDX_CTRL:     w_rdata = {29'b0, r_irq_en, r_auto, r_en};
            IDX_PRESCALE: w_rdata = {16'b0, r_prescale};
            IDX_RELOAD:   w_rdata = r_reload;
            IDX_COUNT:    w_rdata = r_count;
            IDX_STATUS:   w_rdata = {30'b0, r_en, r_expired};
            default:      w_rdata = '0;
         endcase
      end
   end

   assign IOBUS_IN = w_rdata;
   assign INTR     = (r_hold != '0);

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Scoreboard bench for otter_iobus_timer: expectations are queued when
// stimulus is applied and popped when the combinational readback is sampled.
module tb_otter_iobus_timer;

   localparam logic [31:0] BASE     = 32'h1100_0100;
   localparam logic [31:0] A_CTRL   = BASE + 32'h00;
   localparam logic [31:0] A_PRE    = BASE + 32'h04;
   localparam logic [31:0] A_REL    = BASE + 32'h08;
   localparam logic [31:0] A_CNT    = BASE + 32'h0C;
   localparam logic [31:0] A_STA    = BASE + 32'h10;
   localparam logic [31:0] A_R6     = BASE + 32'h18;
   localparam logic [31:0] A_R7     = BASE + 32'h1C;
   localparam logic [31:0] A_UNSEL  = 32'h1100_0200;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_IN;
   logic        INTR;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   otter_iobus_timer #(.BASE_ADDR(BASE), .INTR_HOLD(4)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .IOBUS_IN   (IOBUS_IN),
      .INTR       (INTR)
   );

   always #5 CLK = ~CLK;

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      IOBUS_ADDR = a;
      IOBUS_OUT  = d;
      IOBUS_WR   = 1'b1;
      cycle();
      IOBUS_WR   = 1'b0;
      IOBUS_OUT  = '0;
   endtask

   task automatic do_reset();
      RESET    = 1'b1;
      IOBUS_WR = 1'b0;
      cycle();
      RESET    = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] g, e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         IOBUS_ADDR = BASE + 32'(i * 4);
         exp_q.push_back(32'h0);
         #1;
         g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin
            n_err++;
            $display("FAIL reset_read off=0x%0h got=%h exp=%h", i * 4, g, e);
         end
      end
      exp_q.push_back(32'h0);
      #1;
      g = {31'b0, INTR}; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset_intr got=%h exp=%h", g, e); end
      IOBUS_ADDR = A_UNSEL;
      exp_q.push_back(32'h0);
      #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset_unsel got=%h exp=%h", g, e); end
   endtask

   task automatic test_regs();
      logic [31:0] g, e;
      logic [31:0] ta [8];
      logic [31:0] te [8];
      do_reset();
      wr(A_CTRL, 32'hFFFF_FFFF);
      wr(A_PRE,  32'h1234_5678);
      wr(A_REL,  32'hDEAD_BEEF);
      wr(A_R6,   32'h0000_0000);
      ta[0] = A_CTRL;        te[0] = 32'h0000_0007;
      ta[1] = A_PRE;         te[1] = 32'h0000_5678;
      ta[2] = A_REL;         te[2] = 32'hDEAD_BEEF;
      ta[3] = A_R6;          te[3] = 32'h0;
      ta[4] = A_R7;          te[4] = 32'h0;
      ta[5] = BASE + 32'h5;  te[5] = 32'h0000_5678;
      ta[6] = A_UNSEL;       te[6] = 32'h0;
      ta[7] = 32'h1100_00E8; te[7] = 32'h0;
      for (int i = 0; i < 8; i++) begin
         IOBUS_ADDR = ta[i];
         exp_q.push_back(te[i]);
         #1;
         g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin
            n_err++;
            $display("FAIL regs_rw addr=%h got=%h exp=%h", ta[i], g, e);
         end
      end
   endtask

   task automatic test_auto_reload();
      logic [31:0] g, e;
      logic        ih;
      do_reset();
      wr(A_PRE, 32'd2);
      wr(A_REL, 32'd3);
      wr(A_CNT, 32'd3);
      wr(A_CTRL, 32'h7);
      for (int k = 1; k <= 30; k++) begin
         cycle();
         ih = ((k >= 12) && (k <= 15)) || ((k >= 24) && (k <= 27));
         exp_q.push_back((k >= 12) ? 32'h3 : 32'h2);
         exp_q.push_back(32'(3 - ((k / 3) % 4)));
         exp_q.push_back({31'b0, ih});
         IOBUS_ADDR = A_STA; #1;
         g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL auto_status k=%0d got=%h exp=%h", k, g, e); end
         IOBUS_ADDR = A_CNT; #1;
         g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL auto_count k=%0d got=%h exp=%h", k, g, e); end
         #1;
         g = {31'b0, INTR}; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL auto_intr k=%0d got=%h exp=%h", k, g, e); end
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] g, e;
      do_reset();
      wr(A_PRE, 32'd0);
      wr(A_CNT, 32'd2);
      wr(A_CTRL, 32'h5);
      for (int k = 1; k <= 10; k++) begin
         cycle();
         exp_q.push_back((k >= 3) ? 32'h4 : 32'h5);
         exp_q.push_back((k >= 2) ? 32'h0 : 32'(2 - k));
         exp_q.push_back(((k >= 3) && (k <= 6)) ? 32'h1 : 32'h0);
         IOBUS_ADDR = A_CTRL; #1;
         g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL oneshot_ctrl k=%0d got=%h exp=%h", k, g, e); end
         IOBUS_ADDR = A_CNT; #1;
         g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, g, e); end
         #1;
         g = {31'b0, INTR}; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL oneshot_intr k=%0d got=%h exp=%h", k, g, e); end
      end
   endtask

   task automatic test_clear_collision();
      logic [31:0] g, e;
      do_reset();
      wr(A_PRE, 32'd0);
      wr(A_REL, 32'd5);
      wr(A_CNT, 32'd2);
      wr(A_CTRL, 32'h3);
      cycle();
      cycle();
      // this write lands on the expiry edge
      wr(A_STA, 32'h1);
      exp_q.push_back(32'h3);
      IOBUS_ADDR = A_STA; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL clr_same_cycle got=%h exp=%h", g, e); end
      wr(A_STA, 32'h1);
      exp_q.push_back(32'h2);
      IOBUS_ADDR = A_STA; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL clr_next_cycle got=%h exp=%h", g, e); end
      for (int k = 0; k < 5; k++) cycle();
      exp_q.push_back(32'h3);
      IOBUS_ADDR = A_STA; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL clr_reexpire got=%h exp=%h", g, e); end
      wr(A_STA, 32'h0);
      exp_q.push_back(32'h3);
      IOBUS_ADDR = A_STA; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL clr_write0 got=%h exp=%h", g, e); end
      wr(A_STA, 32'h1);
      exp_q.push_back(32'h2);
      IOBUS_ADDR = A_STA; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL clr_write1 got=%h exp=%h", g, e); end
   endtask

   task automatic test_count_priority_reset();
      logic [31:0] g, e;
      do_reset();
      wr(A_PRE, 32'd0);
      wr(A_REL, 32'd9);
      wr(A_CNT, 32'd50);
      wr(A_CTRL, 32'h7);
      wr(A_CNT, 32'd100);
      exp_q.push_back(32'd100);
      IOBUS_ADDR = A_CNT; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL cnt_write_wins got=%0d exp=%0d", g, e); end
      cycle();
      exp_q.push_back(32'd99);
      IOBUS_ADDR = A_CNT; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL cnt_decrement got=%0d exp=%0d", g, e); end
      wr(A_CNT, 32'd0);
      cycle();
      exp_q.push_back(32'h1);
      exp_q.push_back(32'd9);
      #1;
      g = {31'b0, INTR}; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL pre_reset_intr got=%h exp=%h", g, e); end
      IOBUS_ADDR = A_CNT; #1;
      g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL pre_reset_reload got=%0d exp=%0d", g, e); end
      do_reset();
      exp_q.push_back(32'h0);
      g = {31'b0, INTR}; e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL midrun_reset_intr got=%h exp=%h", g, e); end
      for (int i = 0; i < 8; i++) begin
         IOBUS_ADDR = BASE + 32'(i * 4);
         exp_q.push_back(32'h0);
         #1;
         g = IOBUS_IN; e = exp_q.pop_front(); n_cmp++;
         if (g !== e) begin
            n_err++;
            $display("FAIL midrun_reset_read off=0x%0h got=%h exp=%h", i * 4, g, e);
         end
      end
   endtask

   initial begin
      RESET      = 1'b0;
      IOBUS_ADDR = '0;
      IOBUS_OUT  = '0;
      IOBUS_WR   = 1'b0;
      test_reset();
      test_regs();
      test_auto_reload();
      test_oneshot();
      test_clear_collision();
      test_count_priority_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
